// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pkg: shared sizing helpers for the pipelined adder
// Revision: 1.0
// ---------------------------------------------------------------------------
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages > 0) && (width > 0) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_adder_if: operand and result handshake bundle for pipelined_adder
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_chunk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_chunk: combinational CHUNK-bit ripple adder built from full-adder cells
// Revision: 1.0
// ---------------------------------------------------------------------------
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // Each cell keeps its own carry nets so the ripple chain is not one self-referencing vector.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_chain
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout     = g_fa[CHUNK-1].co;
  assign c_msb_in = g_fa[CHUNK-1].ci;

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_adder: STAGES-deep chunked ripple adder/subtractor with valid/ready flow control
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] load_en;
  logic [STAGES-1:0] src_valid;

  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_ctrl
    // Closed form of the stall chain: a stage can load if the head drains or any later slot is a bubble.
    assign load_en[k] = bus.out_ready | ~(&valid_q[STAGES-1:k]);
    if (k == 0) begin : g_head
      assign src_valid[k] = bus.in_valid;
    end else begin : g_body
      assign src_valid[k] = valid_q[k-1];
    end
  end

  assign valid_d = (valid_q & ~load_en) | (src_valid & load_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = load_en[0];
  assign bus.out_valid = valid_q[STAGES-1];

  // Operand skew: upper chunks not yet added ride along with their transaction.
  for (genvar k = 0; k < STAGES-1; k++) begin : g_opnd
    localparam int REM_W = WIDTH - (k+1)*CHUNK;
    logic [REM_W-1:0] a_rem_d;
    logic [REM_W-1:0] b_rem_d;
    logic [REM_W-1:0] a_rem_q;
    logic [REM_W-1:0] b_rem_q;

    if (k == 0) begin : g_from_bus
      assign a_rem_d = bus.a[WIDTH-1:CHUNK];
      assign b_rem_d = b_eff[WIDTH-1:CHUNK];
    end else begin : g_from_prev
      assign a_rem_d = g_opnd[k-1].a_rem_q[REM_W+CHUNK-1:CHUNK];
      assign b_rem_d = g_opnd[k-1].b_rem_q[REM_W+CHUNK-1:CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_rem_q <= '0;
        b_rem_q <= '0;
      end else if (load_en[k] & src_valid[k]) begin
        a_rem_q <= a_rem_d;
        b_rem_q <= b_rem_d;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]       op_a;
    logic [CHUNK-1:0]       op_b;
    logic [CHUNK-1:0]       chunk_sum;
    logic                   carry_in;
    logic                   chunk_cout;
    logic                   chunk_cmsb;
    logic [(k+1)*CHUNK-1:0] sum_d;
    logic [(k+1)*CHUNK-1:0] sum_q;
    logic                   carry_q;

    if (k == 0) begin : g_first
      assign op_a     = bus.a[CHUNK-1:0];
      assign op_b     = b_eff[CHUNK-1:0];
      assign carry_in = c0;
      assign sum_d    = chunk_sum;
    end else begin : g_next
      assign op_a     = g_opnd[k-1].a_rem_q[CHUNK-1:0];
      assign op_b     = g_opnd[k-1].b_rem_q[CHUNK-1:0];
      assign carry_in = g_stage[k-1].carry_q;
      assign sum_d    = {chunk_sum, g_stage[k-1].sum_q};
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a        (op_a),
      .b        (op_b),
      .cin      (carry_in),
      .sum      (chunk_sum),
      .cout     (chunk_cout),
      .c_msb_in (chunk_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (load_en[k] & src_valid[k]) begin
        sum_q   <= sum_d;
        carry_q <= chunk_cout;
      end
    end

    if (k == STAGES-1) begin : g_out
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load_en[k] & src_valid[k]) begin
          ovf_q <= chunk_cout ^ chunk_cmsb;
        end
      end
      assign bus.sum  = sum_q;
      assign bus.cout = carry_q;
      assign bus.ovf  = ovf_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_adder: directed and random scoreboard bench for pipelined_adder
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  typedef logic [33:0] exp_t;  // {cout, ovf, sum[31:0]}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8))  if8 ();
  pipelined_adder_if #(.WIDTH(32)) if4 ();
  pipelined_adder_if #(.WIDTH(32)) if1 ();

  pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Index 0: 8/2, index 1: 32/4, index 2: 32/1
  logic [2:0]  vin, cin_d, sub_d, ordy;
  logic [31:0] a_d [3];
  logic [31:0] b_d [3];
  logic [2:0]  irdy, ov, co, of;
  logic [31:0] so  [3];
  int          WD  [3] = '{8, 32, 32};

  assign if8.in_valid = vin[0];  assign if8.a = a_d[0][7:0]; assign if8.b = b_d[0][7:0];
  assign if8.cin = cin_d[0];     assign if8.sub = sub_d[0];  assign if8.out_ready = ordy[0];
  assign if4.in_valid = vin[1];  assign if4.a = a_d[1];      assign if4.b = b_d[1];
  assign if4.cin = cin_d[1];     assign if4.sub = sub_d[1];  assign if4.out_ready = ordy[1];
  assign if1.in_valid = vin[2];  assign if1.a = a_d[2];      assign if1.b = b_d[2];
  assign if1.cin = cin_d[2];     assign if1.sub = sub_d[2];  assign if1.out_ready = ordy[2];

  assign irdy = {if1.in_ready, if4.in_ready, if8.in_ready};
  assign ov   = {if1.out_valid, if4.out_valid, if8.out_valid};
  assign co   = {if1.cout, if4.cout, if8.cout};
  assign of   = {if1.ovf, if4.ovf, if8.ovf};
  assign so[0] = {24'd0, if8.sum};
  assign so[1] = if4.sum;
  assign so[2] = if1.sum;

  int   total = 0;
  int   bad   = 0;
  logic [2:0] acc;
  int   emitted [3] = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum/difference for cout, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    longint mask, half, ua, ub, sa, sb, r, sr, ci;
    logic   cout_m, ovf_m;
    logic [31:0] sum_m;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    ci   = c ? 1 : 0;
    if (s) begin
      r      = ua - ub;
      cout_m = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r      = ua + ub + ci;
      cout_m = (r > mask);
      sr     = sa + sb + ci;
    end
    ovf_m = (sr >= half) || (sr < -half);
    r     = r & mask;
    sum_m = r[31:0];
    return {cout_m, ovf_m, sum_m};
  endfunction

  function automatic void qpush(input int i, input exp_t v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Called just after a falling edge with inputs set; scores the coming rising edge.
  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && ordy[i]) begin
        emitted[i]++;
        if (qsize(i) == 0) check($sformatf("spurious_out%0d", i), 64'(ov[i]), 64'd0);
        else check($sformatf("scoreboard%0d", i), 64'({co[i], of[i], so[i]}), 64'(qpop(i)));
      end
      acc[i] = vin[i] & irdy[i];
      if (acc[i]) qpush(i, model(WD[i], a_d[i], b_d[i], cin_d[i], sub_d[i]));
    end
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s,
                         input logic [7:0] es, input logic eco, input logic eov);
    vin[0] = 1'b1; a_d[0] = {24'd0, a}; b_d[0] = {24'd0, b};
    cin_d[0] = c; sub_d[0] = s; ordy[0] = 1'b1;
    tick();
    check({tag, "_accept"}, 64'(acc[0]), 64'd1);
    vin[0] = 1'b0;
    check({tag, "_valid_c1"}, 64'(ov[0]), 64'd0);
    tick();
    check({tag, "_valid_c2"}, 64'(ov[0]), 64'd1);
    check({tag, "_sum"},  64'(so[0]), 64'(es));
    check({tag, "_cout"}, 64'(co[0]), 64'(eco));
    check({tag, "_ovf"},  64'(of[0]), 64'(eov));
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ba [6];
    logic [7:0] bb [6];
    logic [5:0] bc, bs;
    int   sent, e0, n1, n2;
    logic [2:0] pend;
    exp_t held;
    localparam int NRND = 10000;

    rst_n = 1'b0; vin = '0; ordy = '1; cin_d = '0; sub_d = '0; acc = '0;
    for (int i = 0; i < 3; i++) begin a_d[i] = '0; b_d[i] = '0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid%0d", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst_sum%0d", i),       64'(so[i]), 64'd0);
      check($sformatf("rst_cout%0d", i),      64'(co[i]), 64'd0);
      check($sformatf("rst_ovf%0d", i),       64'(of[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_one("basic_add",  8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0);
    run_one("chunk_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_one("wrap",       8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_one("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_one("sub_ovf",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: six back-to-back operands, consumer stalls cycles 3..7.
    for (int t = 0; t < 6; t++) begin
      ba[t] = 8'($urandom); bb[t] = 8'($urandom);
      bc[t] = 1'($urandom_range(1)); bs[t] = 1'($urandom_range(1));
    end
    held = model(8, {24'd0, ba[1]}, {24'd0, bb[1]}, bc[1], bs[1]);
    sent = 0; e0 = emitted[0];
    for (int c = 0; c < 40 && (emitted[0] - e0) < 6; c++) begin
      ordy[0] = !(c >= 3 && c <= 7);
      vin[0]  = (sent < 6);
      if (sent < 6) begin
        a_d[0] = {24'd0, ba[sent]}; b_d[0] = {24'd0, bb[sent]};
        cin_d[0] = bc[sent]; sub_d[0] = bs[sent];
      end
      #1;
      if (c < 3) check("bp_in_ready_open", 64'(irdy[0]), 64'd1);
      if (c >= 3 && c <= 7) begin
        check("bp_in_ready_full", 64'(irdy[0]), 64'd0);
        check("bp_hold_valid",    64'(ov[0]),   64'd1);
        check("bp_hold_result",   64'({co[0], of[0], so[0]}), 64'(held));
      end
      tick();
      if (acc[0]) sent++;
    end
    vin[0] = 1'b0; ordy[0] = 1'b1;
    check("bp_sent",    64'(sent), 64'd6);
    check("bp_emitted", 64'(emitted[0] - e0), 64'd6);
    check("bp_drained", 64'(qsize(0)), 64'd0);

    // Reset with two transactions held in the pipe.
    ordy[0] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      vin[0] = 1'b1; a_d[0] = 32'h11 + 32'(t); b_d[0] = 32'h22; cin_d[0] = 1'b0; sub_d[0] = 1'b0;
      tick();
      check("rst_fill_accept", 64'(acc[0]), 64'd1);
    end
    vin[0] = 1'b0;
    check("rst_pre_valid", 64'(ov[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(ov[0]), 64'd0);
    check("rst_async_sum",   64'(so[0]), 64'd0);
    check("rst_async_cout",  64'(co[0]), 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    rst_n = 1'b1; ordy[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_no_stale", 64'(ov[0]), 64'd0);
    end

    // Random traffic on the 32/4 and 32/1 instances.
    n1 = 0; n2 = 0; pend = '0;
    for (int cyc = 0; cyc < 60000 && (n1 < NRND || n2 < NRND); cyc++) begin
      for (int i = 1; i < 3; i++) begin
        if (!pend[i] && ((i == 1) ? n1 : n2) < NRND && $urandom_range(3) != 0) begin
          a_d[i] = $urandom; b_d[i] = $urandom;
          cin_d[i] = 1'($urandom_range(1)); sub_d[i] = 1'($urandom_range(1));
          pend[i] = 1'b1;
        end
        vin[i]  = pend[i];
        ordy[i] = ($urandom_range(3) != 0);
      end
      tick();
      if (acc[1]) begin pend[1] = 1'b0; n1++; end
      if (acc[2]) begin pend[2] = 1'b0; n2++; end
    end
    vin = '0; ordy = '1;
    for (int c = 0; c < 20 && (qsize(1) != 0 || qsize(2) != 0); c++) tick();
    check("rnd_count_s4", 64'(n1), 64'(NRND));
    check("rnd_count_s1", 64'(n2), 64'(NRND));
    check("rnd_drain_s4", 64'(qsize(1)), 64'd0);
    check("rnd_drain_s1", 64'(qsize(2)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
